// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//
// Iterative 32x32 unsigned shift-add multiplier. It owns no adder: every RUN
// cycle it presents the accumulator high word and (conditionally) the
// multiplicand to the functional unit's shared 32-bit carry-lookahead adder,
// then folds the returned sum and carry-out into a 64-bit running product.
//
// Handshake (valid/ready): a request is transferred on a rising edge where
// start=1 and ready=1. ready is high in IDLE and DONE, low in RUN. A start
// seen while ready=0 is dropped (no queuing). done pulses for exactly one
// cycle when product becomes valid. product then holds until the next
// transfer reloads the accumulator.
//
// Ports:
//   clk       in   1   rising-edge clock
//   reset     in   1   synchronous, active-high reset
//   start     in   1   request, accepted only while ready=1
//   a         in  32   multiplicand, sampled on accept
//   b         in  32   multiplier, sampled on accept
//   ready     out  1   can accept a new request
//   done      out  1   one-cycle pulse, product valid
//   product   out 64   {hi,lo}
//   add_a     out 32   adder operand A (accumulator high word)
//   add_b     out 32   adder operand B (multiplicand or 0)
//   add_cin   out  1   adder carry-in (always 0)
//   add_s     in  32   adder sum
//   add_cout  in   1   adder carry-out
//
// Build option: define SEQ_MULTIPLIER_EARLY_TERM_EN to finish as soon as all
// multiplier bits left are zero (the remaining shifts are done in one step
// by a barrel shifter). Products are identical either way; only latency
// changes. The state register (state) is a named enum for checker binding.
// -----------------------------------------------------------------------------
module seq_multiplier (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        done,
  output logic [63:0] product,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_s,
  input  logic        add_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [5:0]  cnt;

`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
  // No multiplier bits left: every remaining iteration would add zero, so the
  // only effect left is shifting the product right by the remaining count.
  logic        skip;
  logic [63:0] shifted;
  assign skip    = (mplier == 32'd0);
  assign shifted = {hi, lo} >> cnt;
`endif

  // Adder operands are combinational from registered state. Outside RUN the
  // adder result is ignored, so B is forced to zero there.
  assign add_a   = hi;
  assign add_b   = ((state == RUN) && mplier[0]) ? mcand : 32'd0;
  assign add_cin = 1'b0;
  assign product = {hi, lo};

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      cnt    <= 6'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            hi     <= 32'd0;
            lo     <= 32'd0;
            cnt    <= 6'd32;
            state  <= RUN;
            ready  <= 1'b0;
          end else begin
            state  <= IDLE;
            ready  <= 1'b1;
          end
        end

        RUN: begin
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
          if (skip) begin
            {hi, lo} <= shifted;
            cnt      <= 6'd0;
            state    <= DONE;
            ready    <= 1'b1;
            done     <= 1'b1;
          end else
`endif
          begin
            // Carry-out is bit 32 of the partial sum and lands in hi[31];
            // sum bit 0 retires into the top of lo.
            {hi, lo} <= {add_cout, add_s, lo[31:1]};
            mplier   <= mplier >> 1;
            cnt      <= cnt - 6'd1;
            if (cnt == 6'd1) begin
              state <= DONE;
              ready <= 1'b1;
              done  <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
